i2c_slave_regbank: RTL and testbench

Register bank that sits directly behind the I2C slave's RAM port on the Spartan-3E LCD/buttons/switches board. It answers the slave's reads with local board status (switches, buttons, press counter, ID, text readback). It captures the slave's writes into a 16-byte LCD text buffer, which it exposes to the LCD driver through a read port and a dirty/ack handshake.

---
 rtl/i2c_regbank_pkg.sv | 18 +
 rtl/i2c_regbank_debounce.sv | 64 ++++++
 rtl/i2c_slave_regbank.sv | 122 ++++++++++++
 tb/tb_i2c_slave_regbank.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_regbank_pkg.sv
`default_nettype none
// ============================================================================
// Module   : i2c_regbank_pkg
// Purpose  : Shared constants for the I2C slave register bank.
// Revision : 1.0 - initial release
// ============================================================================
package i2c_regbank_pkg;

    localparam logic [7:0] ADDR_SW    = 8'h00;
    localparam logic [7:0] ADDR_BTN   = 8'h01;
    localparam logic [7:0] ADDR_CNT   = 8'h02;
    localparam logic [7:0] ADDR_ID    = 8'h03;

    localparam int         TEXT_DEPTH = 16;
    localparam logic [7:0] TEXT_FILL  = 8'h20;

endpackage
`default_nettype wire

// File: rtl/i2c_regbank_debounce.sv
`default_nettype none
// ============================================================================
// Module   : i2c_regbank_debounce
// Purpose  : 2-flop synchronizer with optional per-bit debounce
//            (enabled by macro REGBANK_DEBOUNCE_EN).
// Revision : 1.0 - initial release
// ============================================================================
module i2c_regbank_debounce #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= din;
            r_sync2 <= r_sync1;
        end
    end

`ifdef REGBANK_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            logic [CNT_W-1:0] r_cnt;
            logic             r_q;

            // Output follows only after DEBOUNCE_CYCLES consecutive disagreeing samples.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_cnt <= '0;
                    r_q   <= 1'b0;
                end else if (r_sync2[i] != r_q) begin
                    if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                        r_cnt <= '0;
                        r_q   <= r_sync2[i];
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end else begin
                    r_cnt <= '0;
                end
            end

            assign dout[i] = r_q;
        end
    endgenerate
`else
    assign dout = r_sync2;
`endif

endmodule
`default_nettype wire

// File: rtl/i2c_slave_regbank.sv
`default_nettype none
// ============================================================================
// Module   : i2c_slave_regbank
// Purpose  : Register bank behind the I2C slave RAM port: board status reads,
//            16-byte LCD text buffer with dirty/ack handshake.
//            Debounce selected by macro REGBANK_DEBOUNCE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_slave_regbank
    import i2c_regbank_pkg::*;
#(
    parameter int         DEBOUNCE_CYCLES = 500000,
    parameter logic [7:0] ID_VALUE        = 8'hA5,
    parameter logic [7:0] TEXT_BASE       = 8'h10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] ram_addr,
    input  logic [7:0] remote_din,
    input  logic       remote_w,
    output logic [7:0] local_dout,
    input  logic [7:0] switches,
    input  logic [3:0] buttons,
    input  logic [3:0] lcd_rd_addr,
    output logic [7:0] lcd_rd_data,
    output logic       lcd_dirty,
    input  logic       lcd_ack
);

    logic [7:0] w_sw_q;
    logic [3:0] w_btn_q;

    i2c_regbank_debounce #(.WIDTH(8), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sw_db (
        .clk   (clk),
        .reset (reset),
        .din   (switches),
        .dout  (w_sw_q)
    );

    i2c_regbank_debounce #(.WIDTH(4), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_db (
        .clk   (clk),
        .reset (reset),
        .din   (buttons),
        .dout  (w_btn_q)
    );

    logic [7:0] r_addr_d;
    logic       r_w_d;
    logic       r_rst_mask;
    logic [3:0] r_btn_prev;
    logic [7:0] r_press_cnt;
    logic [7:0] r_text [TEXT_DEPTH];
    logic [7:0] r_local_dout;
    logic [7:0] r_lcd_rd_data;
    logic       r_lcd_dirty;

    logic       w_wr_accept;
    logic       w_text_wr;
    logic       w_btn_rise;
    logic [7:0] w_rd_data;

    // The slave bumps the address together with the strobe, so writes use last cycle's address.
    assign w_wr_accept = remote_w & ~r_w_d & ~r_rst_mask;
    assign w_text_wr   = w_wr_accept & (r_addr_d[7:4] == TEXT_BASE[7:4]);
    assign w_btn_rise  = |(w_btn_q & ~r_btn_prev);

    always_comb begin
        w_rd_data = 8'h00;
        case (ram_addr)
            ADDR_SW:  w_rd_data = w_sw_q;
            ADDR_BTN: w_rd_data = {4'b0000, w_btn_q};
            ADDR_CNT: w_rd_data = r_press_cnt;
            ADDR_ID:  w_rd_data = ID_VALUE;
            default: begin
                if (ram_addr[7:4] == TEXT_BASE[7:4]) begin
                    w_rd_data = r_text[ram_addr[3:0]];
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr_d      <= 8'h00;
            r_w_d         <= 1'b0;
            r_rst_mask    <= 1'b1;
            r_btn_prev    <= 4'h0;
            r_press_cnt   <= 8'h00;
            r_local_dout  <= 8'h00;
            r_lcd_rd_data <= TEXT_FILL;
            r_lcd_dirty   <= 1'b0;
            for (int i = 0; i < TEXT_DEPTH; i++) begin
                r_text[i] <= TEXT_FILL;
            end
        end else begin
            r_addr_d      <= ram_addr;
            r_w_d         <= remote_w;
            r_rst_mask    <= 1'b0;
            r_btn_prev    <= w_btn_q;
            r_local_dout  <= w_rd_data;
            r_lcd_rd_data <= r_text[lcd_rd_addr];
            if (w_btn_rise) begin
                r_press_cnt <= r_press_cnt + 8'd1;
            end
            if (w_text_wr) begin
                r_text[r_addr_d[3:0]] <= remote_din;
            end
            // A same-cycle text write beats the ack.
            if (w_text_wr) begin
                r_lcd_dirty <= 1'b1;
            end else if (lcd_ack) begin
                r_lcd_dirty <= 1'b0;
            end
        end
    end

    assign local_dout  = r_local_dout;
    assign lcd_rd_data = r_lcd_rd_data;
    assign lcd_dirty   = r_lcd_dirty;

endmodule
`default_nettype wire

// File: tb/tb_i2c_slave_regbank.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_slave_regbank
// Purpose  : Randomized scoreboard bench for i2c_slave_regbank against a
//            behavioural model (honours REGBANK_DEBOUNCE_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_slave_regbank;

`ifdef REGBANK_DEBOUNCE_EN
    localparam int DB = 8;
`else
    localparam int DB = 0;
`endif
    localparam int         MIN_PRESS = (DB > 0) ? DB : 1;
    localparam logic [7:0] C_BASE    = 8'h10;
    localparam logic [7:0] C_ID      = 8'hA5;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] ram_addr;
    logic [7:0] remote_din;
    logic       remote_w;
    logic [7:0] local_dout;
    logic [7:0] switches;
    logic [3:0] buttons;
    logic [3:0] lcd_rd_addr;
    logic [7:0] lcd_rd_data;
    logic       lcd_dirty;
    logic       lcd_ack;

    i2c_slave_regbank #(
        .DEBOUNCE_CYCLES (8),
        .ID_VALUE        (C_ID),
        .TEXT_BASE       (C_BASE)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ram_addr    (ram_addr),
        .remote_din  (remote_din),
        .remote_w    (remote_w),
        .local_dout  (local_dout),
        .switches    (switches),
        .buttons     (buttons),
        .lcd_rd_addr (lcd_rd_addr),
        .lcd_rd_data (lcd_rd_data),
        .lcd_dirty   (lcd_dirty),
        .lcd_ack     (lcd_ack)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [7:0] m_text [16];
    logic       m_dirty;
    logic [7:0] m_cnt;
    logic [7:0] m_sw;
    logic [3:0] m_btn;

    typedef struct {
        int         kind;
        logic [7:0] exp;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always @(negedge clk) begin
        exp_t       e;
        logic [7:0] act;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            case (e.kind)
                0:       act = local_dout;
                1:       act = lcd_rd_data;
                default: act = {7'b0, lcd_dirty};
            endcase
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL %s: got %02h expected %02h", e.name, act, e.exp);
            end
        end
    end

    function automatic logic [7:0] mread(input logic [7:0] a);
        if (a == 8'h00) return m_sw;
        if (a == 8'h01) return {4'b0, m_btn};
        if (a == 8'h02) return m_cnt;
        if (a == 8'h03) return C_ID;
        if (a[7:4] == C_BASE[7:4]) return m_text[a[3:0]];
        return 8'h00;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int kind, input logic [7:0] exp, input string nm);
        exp_t e;
        e.kind = kind;
        e.exp  = exp;
        e.name = nm;
        exp_q.push_back(e);
    endtask

    task automatic rd_check(input logic [7:0] a, input string nm);
        ram_addr = a;
        tick(1);
        push(0, mread(a), $sformatf("%s@%02h", nm, a));
        tick(1);
    endtask

    task automatic lcd_check(input logic [3:0] idx, input string nm);
        lcd_rd_addr = idx;
        tick(1);
        push(1, m_text[idx], $sformatf("%s[%0d]", nm, idx));
        tick(1);
    endtask

    task automatic dirty_check(input string nm);
        push(2, {7'b0, m_dirty}, nm);
        tick(1);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_text[i] = 8'h20;
        m_dirty = 1'b0;
        m_cnt   = 8'h00;
        m_sw    = 8'h00;
        m_btn   = 4'h0;
    endtask

    // Slave protocol: address moves to a+1 in the same cycle the strobe rises.
    task automatic write_txn(input logic [7:0] a, input logic [7:0] d,
                             input int len, input logic ack);
        ram_addr = a;
        tick(10);
        ram_addr   = a + 8'd1;
        remote_din = d;
        remote_w   = 1'b1;
        lcd_ack    = ack;
        tick(1);
        lcd_ack = 1'b0;
        if (a[7:4] == C_BASE[7:4]) begin
            m_text[a[3:0]] = d;
            m_dirty        = 1'b1;
        end else if (ack) begin
            m_dirty = 1'b0;
        end
        for (int i = 1; i < len; i++) begin
            remote_din = 8'($urandom);
            tick(1);
        end
        remote_w = 1'b0;
        tick(2);
    endtask

    task automatic ack_pulse();
        lcd_ack = 1'b1;
        tick(1);
        lcd_ack = 1'b0;
        m_dirty = 1'b0;
        tick(1);
    endtask

    task automatic press(input logic [3:0] mask, input int len);
        buttons = mask;
        tick(len);
        buttons = 4'h0;
        if (mask != 4'h0 && len >= MIN_PRESS) m_cnt = m_cnt + 8'd1;
        tick(DB + 6);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] a;
        logic [7:0] v;
        logic [7:0] cnt_before;

        reset = 1'b1; ram_addr = 8'h00; remote_din = 8'h00; remote_w = 1'b0;
        switches = 8'h00; buttons = 4'h0; lcd_rd_addr = 4'h0; lcd_ack = 1'b0;
        model_reset();
        tick(2);
        checks++;
        if (local_dout !== 8'h00) begin
            errors++;
            $display("FAIL direct_reset_dout: got %02h expected 00", local_dout);
        end
        checks++;
        if (lcd_dirty !== 1'b0) begin
            errors++;
            $display("FAIL direct_reset_dirty: got %0b expected 0", lcd_dirty);
        end
        push(0, 8'h00, "reset_dout");
        push(2, 1'b0,  "reset_dirty");
        push(1, 8'h20, "reset_lcd_rd");
        tick(1);
        reset = 1'b0;
        tick(1);
        rd_check(8'h13, "reset_text");
        rd_check(8'h02, "reset_cnt");

        // Address-skew write, long strobe
        write_txn(8'h12, 8'h41, 20, 1'b0);
        checks++;
        if (lcd_dirty !== 1'b1) begin
            errors++;
            $display("FAIL direct_skew_dirty: got %0b expected 1", lcd_dirty);
        end
        rd_check(8'h12, "skew_wr");
        rd_check(8'h13, "skew_next");
        lcd_check(4'd2, "skew_lcd");
        lcd_check(4'd3, "skew_lcd");
        dirty_check("skew_dirty");

        // Ack collides with accepted text write, then lone ack, then idle ack
        write_txn(8'h15, 8'h33, 3, 1'b1);
        checks++;
        if (lcd_dirty !== 1'b1) begin
            errors++;
            $display("FAIL direct_collide_dirty: got %0b expected 1", lcd_dirty);
        end
        dirty_check("collide_dirty");
        ack_pulse();
        checks++;
        if (lcd_dirty !== 1'b0) begin
            errors++;
            $display("FAIL direct_lone_ack: got %0b expected 0", lcd_dirty);
        end
        dirty_check("lone_ack_dirty");
        ack_pulse();
        dirty_check("idle_ack_dirty");

        // Ignored write outside text window
        write_txn(8'h05, 8'hEE, 4, 1'b0);
        dirty_check("ignored_dirty");
        rd_check(8'h05, "ignored_rd");
        for (int i = 0; i < 16; i++) lcd_check(4'(i), "ignored_text");

        write_txn(8'h1F, 8'h7E, 2, 1'b0);
        rd_check(8'h1F, "last_text");
        rd_check(8'h03, "id");
        checks++;
        if (local_dout !== C_ID) begin
            errors++;
            $display("FAIL direct_id: got %02h expected %02h", local_dout, C_ID);
        end
        rd_check(8'h40, "unmapped");
        checks++;
        if (local_dout !== 8'h00) begin
            errors++;
            $display("FAIL direct_unmapped: got %02h expected 00", local_dout);
        end
        rd_check(8'hFF, "unmapped");

        switches = 8'h5A;
        tick(DB + 4);
        m_sw = 8'h5A;
        rd_check(8'h00, "switches");
        checks++;
        if (local_dout !== 8'h5A) begin
            errors++;
            $display("FAIL direct_switches: got %02h expected 5a", local_dout);
        end
        for (int i = 0; i < 4; i++) begin
            v = 8'($urandom);
            switches = v;
            tick(DB + 4);
            m_sw = v;
            rd_check(8'h00, "sw_rand");
        end

        // Randomized writes with reads, lcd port and dirty checks
        for (int n = 0; n < 24; n++) begin
            if ($urandom_range(0, 2) != 0) a = {C_BASE[7:4], 4'($urandom)};
            else                           a = 8'($urandom);
            write_txn(a, 8'($urandom), $urandom_range(1, 6), 1'($urandom_range(0, 3) == 0));
            dirty_check("rand_dirty");
            rd_check(a, "rand_rd");
            rd_check(a + 8'd1, "rand_rd_next");
            lcd_check(4'($urandom), "rand_lcd");
            if ($urandom_range(0, 2) == 0) begin
                ack_pulse();
                dirty_check("rand_ack");
            end
        end

        // Buttons and press counter
        buttons = 4'b1010;
        tick(DB + 4);
        m_btn = 4'b1010;
        rd_check(8'h01, "btn_level");
        buttons = 4'h0;
        m_cnt   = m_cnt + 8'd1;
        tick(DB + 6);
        m_btn = 4'h0;
        rd_check(8'h01, "btn_release");
        rd_check(8'h02, "cnt_level_press");
`ifdef REGBANK_DEBOUNCE_EN
        press(4'b0001, 5);
        rd_check(8'h02, "cnt_glitch");
`endif
        press(4'b0001, 12);
        rd_check(8'h02, "cnt_press");
        press(4'b0110, 12);
        rd_check(8'h02, "cnt_simul");
        for (int n = 0; n < 10; n++) begin
            press(4'($urandom), $urandom_range(1, 16));
            rd_check(8'h02, "cnt_rand");
        end
        cnt_before = m_cnt;
        for (int n = 0; n < 256; n++) press(4'b0100, MIN_PRESS + 2);
        rd_check(8'h02, "cnt_wrap");
        if (m_cnt != cnt_before) $display("note: model wrap inconsistent");

        // Reset with strobe held high: no write after release
        ram_addr   = 8'h14;
        remote_din = 8'h99;
        tick(2);
        remote_w = 1'b1;
        reset    = 1'b1;
        tick(2);
        reset = 1'b0;
        model_reset();
        tick(5);
        remote_w = 1'b0;
        tick(2);
        dirty_check("rst_strobe_dirty");
        rd_check(8'h14, "rst_strobe_text");
        rd_check(8'h15, "rst_strobe_text");
        rd_check(8'h02, "rst_cnt");

        tick(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
